result_stage: RTL
=================

RESULT_STAGE -- requirements
Module: result_stage

Interface
REQ-001 SHALL have parameter BITS, default 32, which sets the result data width.
REQ-002 SHALL have parameter DEPTH, default 2, fixed at 2 and giving the output buffer entries.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream beat present.
- i_result  in  BITS  result word from the bit-set unit.
- i_error  in  1  upstream error flag (bit index out of range or negative).
- o_ready  out  1  stage can accept a beat.
- o_valid  out  1  head entry present.
- o_result  out  BITS  head entry result.
- o_status  out  4  head flags: [0] error, [1] zero, [2] negative (MSB), [3] one-hot.
- i_ready  in  1  downstream accepts head.
- o_err_cnt  out  8  saturating count of accepted error beats.

Function
REQ-004 SHALL accept a beat (push) in a cycle where i_valid=1 and o_ready=1.
REQ-005 SHALL drain the head entry (pop) in a cycle where o_valid=1 and i_ready=1.
REQ-006 SHALL drive o_ready=1 exactly when occupancy < 2; o_ready SHALL be a register-only function of occupancy, with no combinational path from i_ready.
REQ-007 SHALL drive o_valid=1 exactly when occupancy > 0.
REQ-008 SHALL implement the buffer as a 2-entry circular FIFO with 1-bit read and write pointers that wrap 1->0.
REQ-009 SHALL on push of an error beat (i_error=1) store result 0 and status 4'b0001, ignoring i_result.
REQ-010 SHALL on push of a non-error beat store i_result and status {onehot, MSB, zero, 0}, where:
- zero = (i_result == 0).
- onehot = (exactly one bit of i_result is set).
REQ-011 SHALL compute all flags at push time and store them per entry; flags SHALL NOT be recomputed at the output.
REQ-012 SHALL drive o_result and o_status as 0 when empty.
REQ-013 SHALL have a latency of one cycle: a beat pushed in cycle N into an empty buffer is presented with o_valid=1 in cycle N+1.
REQ-014 SHALL, on simultaneous push and pop with occupancy 1, keep occupancy at 1 and present the new entry in the next cycle.
REQ-015 SHALL perform neither push nor pop when i_valid=1 and the buffer is full (o_ready=0); upstream SHALL hold its beat.
REQ-016 SHALL, on pop with no push, decrement occupancy; pop when empty SHALL be impossible because o_valid=0.
REQ-017 SHALL preserve order: beats leave in acceptance order.
REQ-018 SHALL increment o_err_cnt by 1 on each pushed error beat and saturate it at 255; error beats that are not accepted SHALL NOT count.
REQ-019 SHALL keep o_err_cnt unaffected by pops.

Reset
REQ-020 SHALL, while i_rst=1, asynchronously force:
- occupancy=0, pointers=0.
- o_valid=0, o_ready=0, o_result=0, o_status=0, o_err_cnt=0.
REQ-021 SHALL drive o_ready=1 on the first rising edge of i_clk after i_rst deasserts.
REQ-022 SHALL, on reset asserted mid-operation, discard buffered entries immediately; no beat SHALL emerge after reset.

Verification
REQ-023 Bench SHALL cover single pass: push i_result=32'h0000_0010, i_error=0, i_ready=1 -> next cycle o_valid=1, o_result=32'h10, o_status=4'b1000, then o_valid=0.
REQ-024 Bench SHALL cover full and backpressure: i_ready=0, push 32'h8000_0000 then 32'h0 -> o_ready=0; heads are 32'h8000_0000 (status 4'b1100) then 32'h0 (status 4'b0010); a third beat held by upstream is accepted only after the first pop.
REQ-025 Bench SHALL cover error path: push i_result=32'hFFFF_FFFF with i_error=1 -> o_result=0, o_status=4'b0001, o_err_cnt increments by 1.
REQ-026 Bench SHALL cover saturation: 300 accepted error beats -> o_err_cnt=255 and stays 255.
REQ-027 Bench SHALL cover simultaneous push and pop at occupancy 1 over 6 random beats with i_ready=1 continuously -> throughput of one per cycle, order preserved, occupancy never exceeds 1.
REQ-028 Bench SHALL cover mid-operation reset: i_rst pulsed with 2 entries buffered -> all outputs 0 within the same cycle, o_ready=1 on the edge after release, no stale data emerges.

Source files
------------

// File: rtl/result_stage_if.sv
// Handshake bundle between the bit-set unit, the result stage and its consumer.
// The result stage takes the slave side; the producer/consumer pair takes the master side.
interface result_stage_if #(
  parameter int BITS = 32
);
  logic            i_valid;
  logic [BITS-1:0] i_result;
  logic            i_error;
  logic            o_ready;
  logic            o_valid;
  logic [BITS-1:0] o_result;
  logic [3:0]      o_status;
  logic            i_ready;
  logic [7:0]      o_err_cnt;

  modport slave (
    input  i_valid, i_result, i_error, i_ready,
    output o_ready, o_valid, o_result, o_status, o_err_cnt
  );

  modport master (
    output i_valid, i_result, i_error, i_ready,
    input  o_ready, o_valid, o_result, o_status, o_err_cnt
  );
endinterface

// File: rtl/result_stage.sv
// Two-entry output buffer for bit-set results: flags are computed once at push time
// and held per entry, and accepted error beats are counted with saturation.
module result_stage #(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  result_stage_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem_result [DEPTH];
  logic [3:0]      mem_status [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   occ_nxt;
  logic            ready_q;
  logic [7:0]      err_cnt;
  logic            push;
  logic            pop;
  logic            is_zero;
  logic            is_onehot;
  logic [BITS-1:0] push_result;
  logic [3:0]      push_status;

  assign push = bus.i_valid & ready_q;
  assign pop  = (occ != '0) & bus.i_ready;

  always_comb begin
    is_zero   = (bus.i_result == '0);
    is_onehot = !is_zero && ((bus.i_result & (bus.i_result - BITS'(1))) == '0);
    if (bus.i_error) begin
      push_result = '0;
      push_status = 4'b0001;
    end else begin
      push_result = bus.i_result;
      push_status = {is_onehot, bus.i_result[BITS-1], is_zero, 1'b0};
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + CW'(1);
      2'b01:   occ_nxt = occ - CW'(1);
      default: occ_nxt = occ;
    endcase
  end

  // ready is registered from next occupancy so downstream i_ready never reaches o_ready
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_status[i] <= '0;
      end
    end else begin
      occ     <= occ_nxt;
      ready_q <= (occ_nxt < CW'(DEPTH));
      if (push) begin
        mem_result[wr_ptr] <= push_result;
        mem_status[wr_ptr] <= push_status;
        wr_ptr             <= wr_ptr + PW'(1);
        if (bus.i_error && err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = (occ != '0);
  assign bus.o_result  = (occ != '0) ? mem_result[rd_ptr] : '0;
  assign bus.o_status  = (occ != '0) ? mem_status[rd_ptr] : '0;
  assign bus.o_err_cnt = err_cnt;
endmodule
